// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   EX-stage multi-cycle multiply/divide unit that owns the architectural
//   HI/LO registers.
//   The result is computed in the accepting cycle and parked in pend_hi/pend_lo.
//   It is committed to HI/LO once the modelled latency has elapsed. This keeps
//   the pipeline-visible timing identical to a real iterative unit.
//
// Parameters
//   MULT_CYCLES  accept-to-commit latency of MULT/MULTU (>=1)
//   DIV_CYCLES   accept-to-commit latency of DIV/DIVU  (>=1)
// Ports
//   clk      rising-edge clock
//   reset    async active-low reset, clears all state
//   start    EX instruction is a HI/LO op (qualifies op)
//   op       0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved
//   rs, rt   forwarded operands
//   int_clr  flush: cancels the EX instruction only
//   busy     MULT/DIV in flight
//   hi, lo   architectural HI/LO
module ex_muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        int_clr,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             is_signed;
  logic [63:0]      a_ext, b_ext, prod;
  logic             sa, sb;
  logic [31:0]      a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign accept = start & ~int_clr & ~busy & (op >= OP_MULT) & (op <= OP_MTLO);

  // Multiply: sign-extend (signed) or zero-extend (unsigned) to 64 bits; the
  // low 64 bits of the wide product are the exact two's-complement result.
  assign is_signed = (op == OP_MULT) | (op == OP_DIV);
  assign a_ext = {{32{is_signed & rs[31]}}, rs};
  assign b_ext = {{32{is_signed & rt[31]}}, rt};
  assign prod  = a_ext * b_ext;

  // Divide on magnitudes so that 0x80000000 / -1 never hits a signed
  // overflow; the quotient/remainder signs are reapplied afterwards.
  assign sa     = is_signed & rs[31];
  assign sb     = is_signed & rt[31];
  assign a_mag  = sa ? (~rs + 32'd1) : rs;
  assign b_mag  = sb ? (~rt + 32'd1) : rt;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (sa ^ sb) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = sa ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    dz_d      = dz_q;
    if (accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod;
          dz_d  = 1'b0;
          cnt_d = CNT_W'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          pend_hi_d = rem;
          pend_lo_d = quo;
          dz_d  = (rt == 32'd0);
          cnt_d = CNT_W'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = rs;
        OP_MTLO: lo_d = rs;
        default: ;
      endcase
    end else if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Final cycle: commit, except a divide by zero which leaves HI/LO alone.
      if (cnt_q == CNT_W'(1) && !dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      cnt_q     <= '0;
      dz_q      <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
      dz_q      <= dz_d;
    end
  end

endmodule
